// File: rtl/apb_slave_ctrl_pkg.sv
// Shared types for the APB slave front-end: FSM state encoding and APB response codes.
package apb_slave_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/apb_slave_ctrl_if.sv
// APB4 completer-side bus bundle used between the bus fabric and apb_slave_ctrl.
interface apb_slave_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Handshake: psel&~penable is the setup phase; the access phase (psel&penable) holds all
    // request fields stable until the cycle in which pready=1, which is when prdata/pslverr count.
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slave_ctrl_addr_decode.sv
// Combinational window/alignment check and window-relative offset for an APB byte address.
module apb_slave_ctrl_addr_decode #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH:0]   ADDR_SPAN  = (ADDR_WIDTH+1)'(32'h0000_1000)
) (
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    output logic                  in_range_o,
    output logic                  aligned_o,
    output logic [ADDR_WIDTH-1:0] offset_o
);

    localparam int LSB_W = $clog2(DATA_WIDTH / 8);
    // One extra bit so a window ending exactly at 2^ADDR_WIDTH does not wrap to zero.
    localparam logic [ADDR_WIDTH:0] WIN_END = {1'b0, BASE_ADDR} + ADDR_SPAN;

    logic [ADDR_WIDTH:0] paddr_ext;

    assign paddr_ext  = {1'b0, paddr_i};
    assign in_range_o = (paddr_i >= BASE_ADDR) && (paddr_ext < WIN_END);
    assign offset_o   = paddr_i - BASE_ADDR;

    generate
        if (LSB_W > 0) begin : g_align
            assign aligned_o = (paddr_i[LSB_W-1:0] == '0);
        end else begin : g_no_align
            assign aligned_o = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB4 slave front-end: decodes the window, strobes the register backend once per access,
// holds the bus until the backend acks (or times out) and returns a registered response.
module apb_slave_ctrl
    import apb_slave_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH:0]   ADDR_SPAN  = (ADDR_WIDTH+1)'(32'h0000_1000),
    parameter int                    TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,
    apb_slave_ctrl_if.slave         apb,
    output logic                    wr_en_o,
    output logic                    rd_en_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic [DATA_WIDTH/8-1:0] wr_strb_o,
    input  logic                    be_ack_i,
    input  logic [DATA_WIDTH-1:0]   be_rdata_i,
    output state_t                  state_o
);

    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH/8-1:0] wr_strb_q, wr_strb_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

    logic                    setup;
    logic                    in_range;
    logic                    aligned;
    logic [ADDR_WIDTH-1:0]   offset;

    assign setup = apb.psel & ~apb.penable;

    apb_slave_ctrl_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_SPAN  (ADDR_SPAN)
    ) u_decode (
        .paddr_i    (apb.paddr),
        .in_range_o (in_range),
        .aligned_o  (aligned),
        .offset_o   (offset)
    );

    // Outputs are computed from the next state so that every one of them leaves a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pwrite_d  = pwrite_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = RESP_OKAY;
        prdata_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    pwrite_d  = apb.pwrite;
                    addr_d    = offset;
                    wr_data_d = apb.pwdata;
                    wr_strb_d = apb.pwrite ? apb.pstrb : '0;
                    if (in_range && aligned) begin
                        state_d = ST_REQ;
                        cnt_d   = '0;
                        wr_en_d = apb.pwrite;
                        rd_en_d = ~apb.pwrite;
                    end else begin
                        state_d   = ST_ERR;
                        pready_d  = 1'b1;
                        pslverr_d = RESP_ERR;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                if (!apb.psel) begin
                    // Master abandoned the transfer: drop it silently.
                    state_d = ST_IDLE;
                end else if (be_ack_i) begin
                    state_d  = ST_DONE;
                    pready_d = 1'b1;
                    prdata_d = pwrite_q ? '0 : be_rdata_i;
                end else if (state_q == ST_REQ) begin
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    if ((TIMEOUT != 0) && (cnt_d == TO_VAL)) begin
                        state_d   = ST_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = RESP_ERR;
                    end
                end
            end
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pwrite_q  <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pwrite_q  <= pwrite_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign wr_en_o     = wr_en_q;
    assign rd_en_o     = rd_en_q;
    assign addr_o      = addr_q;
    assign wr_data_o   = wr_data_q;
    assign wr_strb_o   = wr_strb_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Scoreboard bench for apb_slave_ctrl: directed scenarios plus randomized APB traffic.
module tb_apb_slave_ctrl;
    import apb_slave_ctrl_pkg::*;

    localparam int            DW     = 32;
    localparam int            AW     = 32;
    localparam logic [AW-1:0] BASE   = 32'h0000_2000;
    localparam logic [AW-1:0] SPAN32 = 32'h0000_1000;
    localparam logic [AW:0]   SPAN   = {1'b0, SPAN32};
    localparam int            TO     = 16;
    localparam int            RW     = 2 + AW + DW + DW / 8;
    localparam int            PW     = 1 + DW;

    // ---------------- clock / reset ----------------
    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    logic                wr_en, rd_en;
    logic [AW-1:0]       addr;
    logic [DW-1:0]       wr_data;
    logic [DW/8-1:0]     wr_strb;
    logic                be_ack   = 1'b0;
    logic [DW-1:0]       be_rdata = '0;
    state_t              state;

    apb_slave_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

    apb_slave_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .ADDR_SPAN  (SPAN),
        .TIMEOUT    (TO)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .apb        (apb),
        .wr_en_o    (wr_en),
        .rd_en_o    (rd_en),
        .addr_o     (addr),
        .wr_data_o  (wr_data),
        .wr_strb_o  (wr_strb),
        .be_ack_i   (be_ack),
        .be_rdata_i (be_rdata),
        .state_o    (state)
    );

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] exp_q[$];   // {pslverr, prdata} per expected pready
    logic [RW-1:0] req_q[$];   // {wr_en, rd_en, addr, wr_data, wr_strb} per expected strobe

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (apb.pready) begin
            if (exp_q.size() == 0) check("unexpected_pready", apb.pready, 1'b0);
            else check("response", {apb.pslverr, apb.prdata}, exp_q.pop_front());
        end
        if (wr_en || rd_en) begin
            if (req_q.size() == 0) check("unexpected_strobe", {wr_en, rd_en}, 2'b00);
            else check("backend_req", {wr_en, rd_en, addr, wr_data, wr_strb}, req_q.pop_front());
        end
    end

    // ---------------- backend model ----------------
    int            cur_delay = -1;   // cycles after the strobe cycle; <0 = never ack
    logic [DW-1:0] cur_rdata = '0;
    logic          be_busy   = 1'b0;

    initial begin
        forever begin
            @(negedge pclk);
            if ((wr_en || rd_en) && cur_delay >= 0) begin
                be_busy = 1'b1;
                if (cur_delay > 0) begin
                    repeat (cur_delay) @(posedge pclk);
                    #1;
                end
                be_ack   = 1'b1;
                be_rdata = cur_rdata;
                @(posedge pclk);
                #1;
                be_ack   = 1'b0;
                be_rdata = $urandom();
                be_busy  = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apb_idle(input int n);
        if (n > 0) begin
            @(posedge pclk);
            #1;
            apb.psel    = 1'b0;
            apb.penable = 1'b0;
            repeat (n - 1) @(posedge pclk);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input logic [DW/8-1:0] st, input int d, input logic [DW-1:0] rd);
        longint unsigned al, base_l, end_l;
        logic            ok;
        int              lat, exp_lat;
        logic [AW-1:0]   eo;
        logic [DW/8-1:0] es;
        logic [DW-1:0]   er;
        al     = a;
        base_l = BASE;
        end_l  = base_l + SPAN32;
        ok     = (al >= base_l) && (al < end_l) && (al % 4 == 0);
        eo     = a - BASE;
        es     = wr ? st : '0;
        er     = wr ? '0 : rd;
        cur_delay = d;
        cur_rdata = rd;
        if (!ok) begin
            exp_q.push_back({1'b1, {DW{1'b0}}});
            exp_lat = 1;
        end else begin
            req_q.push_back({wr, ~wr, eo, wd, es});
            if (d >= 0 && d <= TO) begin
                exp_q.push_back({1'b0, er});
                exp_lat = 2 + d;
            end else begin
                exp_q.push_back({1'b1, {DW{1'b0}}});
                exp_lat = 2 + TO;
            end
        end
        @(posedge pclk);
        #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
        apb.paddr = a;   apb.pwdata = wd;    apb.pstrb = st;
        @(posedge pclk);
        #1;
        apb.penable = 1'b1;
        lat = 1;
        while (lat < 40) begin
            @(negedge pclk);
            if (apb.pready) break;
            @(posedge pclk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        if (be_busy) begin
            @(posedge pclk);
            #1;
            apb.psel    = 1'b0;
            apb.penable = 1'b0;
            for (int i = 0; i < 40 && be_busy; i++) @(negedge pclk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            kind, d;
        logic [AW-1:0] a;
        logic          w;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0;  apb.pwdata = '0;    apb.pstrb = '0;

        repeat (3) @(negedge pclk);
        check("reset_outputs", {apb.pready, apb.pslverr, apb.prdata, wr_en, rd_en, addr, wr_data, wr_strb}, '0);
        check("reset_state", state, ST_IDLE);
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        apb_idle(2);

        // write, ack one cycle after the strobe
        apb_xfer(1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1, '0);
        apb_idle(1);
        // read, ack in the third WAIT cycle
        apb_xfer(1'b0, BASE + 32'h8, 32'h0, 4'h0, 3, 32'h1234_5678);
        apb_idle(1);
        // window and alignment boundaries
        apb_xfer(1'b0, BASE + SPAN32, 32'h0, 4'h0, 0, 32'h1111_1111);
        apb_xfer(1'b0, BASE + 32'h2, 32'h0, 4'h0, 0, 32'h2222_2222);
        apb_xfer(1'b1, BASE - 32'h4, 32'h5555_AAAA, 4'h3, 0, '0);
        apb_xfer(1'b0, BASE + SPAN32 - 32'h4, 32'h0, 4'h0, 0, 32'hCAFE_F00D);
        apb_xfer(1'b0, BASE, 32'h0, 4'h0, 0, 32'h0BAD_CAFE);
        apb_idle(1);
        // timeout with a late ack that must be ignored
        apb_xfer(1'b0, BASE + 32'hC, 32'h0, 4'h0, TO + 3, 32'h7777_7777);
        apb_idle(2);
        // back-to-back writes
        apb_xfer(1'b1, BASE + 32'h30, 32'hA0A0_A0A0, 4'h5, 0, '0);
        apb_xfer(1'b1, BASE + 32'h34, 32'hB1B1_B1B1, 4'hA, 1, '0);
        apb_idle(2);

        // master drops psel during WAIT; the later ack arrives in IDLE
        cur_delay = 6;
        cur_rdata = 32'h9999_9999;
        req_q.push_back({2'b01, 32'h20, 32'h0, 4'h0});
        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = BASE + 32'h20; apb.pwdata = '0; apb.pstrb = '0;
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        repeat (3) @(negedge pclk);
        @(posedge pclk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check("abort_state", state, ST_IDLE);
        for (int i = 0; i < 20 && be_busy; i++) @(negedge pclk);
        repeat (2) @(negedge pclk);
        check("abort_after_ack_state", state, ST_IDLE);

        // reset during WAIT
        cur_delay = -1;
        req_q.push_back({2'b01, 32'h10, 32'hA5A5_5A5A, 4'h0});
        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = BASE + 32'h10; apb.pwdata = 32'hA5A5_5A5A; apb.pstrb = 4'hF;
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        repeat (4) @(negedge pclk);
        check("pre_reset_state", state, ST_WAIT);
        presetn = 1'b0;
        #1;
        check("midreset_outputs", {apb.pready, apb.pslverr, apb.prdata, wr_en, rd_en, addr, wr_data, wr_strb}, '0);
        check("midreset_state", state, ST_IDLE);
        apb.psel = 1'b0; apb.penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        apb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'h0, 2, 32'h600D_600D);
        apb_idle(1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a    = BASE + AW'($urandom_range(0, 32'h3FF) << 2);
            if (kind == 8) a = a + AW'($urandom_range(1, 3));
            if (kind == 9) a = $urandom_range(0, 1) ? BASE - AW'(4 * $urandom_range(1, 16))
                                                    : BASE + SPAN32 + AW'(4 * $urandom_range(0, 16));
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(TO + 1, TO + 4) : $urandom_range(0, 5);
            w = 1'($urandom_range(0, 1));
            apb_xfer(w, a, $urandom(), 4'($urandom_range(0, 15)), d, $urandom());
            apb_idle($urandom_range(0, 2));
        end

        apb_idle(3);
        repeat (5) @(negedge pclk);
        check("exp_q_drained", exp_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
